// File: rtl/cp_ctrl.sv
// Charge-pump controller: pre-charges the loop filter, then gates PFD up/down
// pulses and switches pump current between acquire and track, with lock detection.
module cp_ctrl #(
    parameter int          PRECHG_CYC = 64,
    parameter int          LOCK_CNT   = 256,
    parameter int          UNLOCK_CNT = 16,
    parameter logic [2:0]  ACQ_CODE   = 3'd7,
    parameter logic [2:0]  TRK_CODE   = 3'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up_in,
    input  logic       down_in,
    output logic       up_out,
    output logic       down_out,
    output logic [2:0] iamp_sel,
    output logic       locked,
    output logic [1:0] state
);

    localparam int MAX_AB = (PRECHG_CYC > LOCK_CNT) ? PRECHG_CYC : LOCK_CNT;
    localparam int MAX_C  = (MAX_AB > UNLOCK_CNT) ? MAX_AB : UNLOCK_CNT;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] PRECHG_LAST = CW'(PRECHG_CYC - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CNT - 1);
    localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_CNT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        ACQUIRE   = 2'd2,
        TRACK     = 2'd3
    } st_t;

    st_t           st;
    logic [CW-1:0] cnt;
    logic          balanced;
    logic          gated_up;
    logic          gated_down;

    assign balanced   = (up_in == down_in);
    assign gated_up   = up_in & ~down_in;
    assign gated_down = down_in & ~up_in;
    assign state      = st;

    // Outputs are computed together with the next state so that every
    // configuration change lands on the same edge as the state change.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            st       <= IDLE;
            cnt      <= '0;
            up_out   <= 1'b0;
            down_out <= 1'b0;
            iamp_sel <= 3'd0;
            locked   <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    st       <= PRECHARGE;
                    cnt      <= '0;
                    up_out   <= 1'b1;
                    down_out <= 1'b0;
                    iamp_sel <= ACQ_CODE;
                    locked   <= 1'b0;
                end
                PRECHARGE: begin
                    if (cnt == PRECHG_LAST) begin
                        st       <= ACQUIRE;
                        cnt      <= '0;
                        up_out   <= gated_up;
                        down_out <= gated_down;
                    end else begin
                        if (cnt != '1) cnt <= cnt + 1'b1;
                        up_out   <= 1'b1;
                        down_out <= 1'b0;
                    end
                    iamp_sel <= ACQ_CODE;
                    locked   <= 1'b0;
                end
                ACQUIRE: begin
                    up_out   <= gated_up;
                    down_out <= gated_down;
                    if (!balanced) begin
                        cnt      <= '0;
                        iamp_sel <= ACQ_CODE;
                        locked   <= 1'b0;
                    end else if (cnt == LOCK_LAST) begin
                        st       <= TRACK;
                        cnt      <= '0;
                        iamp_sel <= TRK_CODE;
                        locked   <= 1'b1;
                    end else begin
                        if (cnt != '1) cnt <= cnt + 1'b1;
                        iamp_sel <= ACQ_CODE;
                        locked   <= 1'b0;
                    end
                end
                TRACK: begin
                    up_out   <= gated_up;
                    down_out <= gated_down;
                    if (balanced) begin
                        cnt      <= '0;
                        iamp_sel <= TRK_CODE;
                        locked   <= 1'b1;
                    end else if (cnt == UNLOCK_LAST) begin
                        st       <= ACQUIRE;
                        cnt      <= '0;
                        iamp_sel <= ACQ_CODE;
                        locked   <= 1'b0;
                    end else begin
                        if (cnt != '1) cnt <= cnt + 1'b1;
                        iamp_sel <= TRK_CODE;
                        locked   <= 1'b1;
                    end
                end
                default: begin
                    st       <= IDLE;
                    cnt      <= '0;
                    up_out   <= 1'b0;
                    down_out <= 1'b0;
                    iamp_sel <= 3'd0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cp_ctrl.md
CP_CTRL -- requirements
Module: cp_ctrl

Interface
REQ-001 Parameter PRECHG_CYC, default 64: cycles of forced up-drive at start-up to pre-charge the loop filter.
REQ-002 Parameter LOCK_CNT, default 256: consecutive balanced cycles needed to declare lock.
REQ-003 Parameter UNLOCK_CNT, default 16: consecutive unbalanced cycles needed to declare loss of lock.
REQ-004 Parameter ACQ_CODE, default 3'd7: current-select code driven during PRECHARGE and ACQUIRE.
REQ-005 Parameter TRK_CODE, default 3'd2: current-select code driven during TRACK.
REQ-006 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-007 Port rst, input, 1: synchronous, active-high reset.
REQ-008 Port en, input, 1: loop enable; low forces IDLE.
REQ-009 Port up_in, input, 1: PFD up request, synchronous to clk.
REQ-010 Port down_in, input, 1: PFD down request, synchronous to clk.
REQ-011 Port up_out, output, 1: gated up control to the charge pump.
REQ-012 Port down_out, output, 1: gated down control to the charge pump.
REQ-013 Port iamp_sel, output, 3: charge-pump current magnitude code; 0 means pump off.
REQ-014 Port locked, output, 1: lock indicator.
REQ-015 Port state, output, 2: current FSM state; IDLE=0, PRECHARGE=1, ACQUIRE=2, TRACK=3.

Function
REQ-016 All outputs shall be registered; an input sampled on edge N affects outputs after edge N, i.e. one-cycle latency.
REQ-017 FSM states: IDLE, PRECHARGE, ACQUIRE, TRACK; one 2-bit state register and one counter of width clog2(max(PRECHG_CYC,LOCK_CNT,UNLOCK_CNT))+1.
REQ-018 IDLE: up_out=0, down_out=0, iamp_sel=0, locked=0, counter=0; en=1 moves to PRECHARGE on the next edge.
REQ-019 PRECHARGE: up_out=1, down_out=0, iamp_sel=ACQ_CODE; up_in and down_in are ignored; counter increments each cycle; after exactly PRECHG_CYC cycles in PRECHARGE, go to ACQUIRE with counter cleared.
REQ-020 ACQUIRE/TRACK gating: up_out = up_in & ~down_in, down_out = down_in & ~up_in; up_in=down_in=1 drives both outputs 0 (no shoot-through).
REQ-021 ACQUIRE: iamp_sel=ACQ_CODE, locked=0; a cycle with up_in==down_in is balanced and increments the counter; an unbalanced cycle clears it to 0.
REQ-022 ACQUIRE -> TRACK on the edge where the counter would reach LOCK_CNT; counter cleared; locked=1 and iamp_sel=TRK_CODE from that edge onward.
REQ-023 TRACK: locked=1, iamp_sel=TRK_CODE; an unbalanced cycle increments the counter, a balanced cycle clears it.
REQ-024 TRACK -> ACQUIRE on the edge where the counter would reach UNLOCK_CNT; counter cleared; locked=0 and iamp_sel=ACQ_CODE from that edge; no re-precharge.
REQ-025 en=0 in any state shall take effect next edge: go to IDLE, outputs per REQ-018, regardless of counter or input values.
REQ-026 The counter shall saturate and never wrap; terminal-count comparisons are on the pre-increment value equal to parameter-1.
REQ-027 iamp_sel and the up_out/down_out gating shall change on the same edge as the state transition; there is no cycle with a mixed old/new configuration.

Reset
REQ-028 rst=1 sampled on an edge shall force state=IDLE, counter=0, up_out=0, down_out=0, iamp_sel=0, locked=0; it has priority over en and all other inputs.
REQ-029 Reset asserted mid-PRECHARGE, ACQUIRE or TRACK shall abandon that operation with no residual pulse on up_out/down_out after the reset edge.
REQ-030 After rst deasserts with en=1, PRECHARGE begins on the first edge with rst=0.

Verification
REQ-031 rst, then en=1 with up_in=0/down_in=1 -> up_out=1, down_out=0, iamp_sel=7 for exactly 64 cycles, then state=2 and down_out=1.
REQ-032 In ACQUIRE, up_in=down_in=0 for 256 cycles -> state=3, locked=1, iamp_sel=2 on the 256th edge; an unbalanced cycle inserted at cycle 255 restarts the count.
REQ-033 In TRACK, up_in=1/down_in=0 for 15 cycles then balanced for 1 cycle -> remains locked; then 16 unbalanced cycles -> state=2, locked=0, iamp_sel=7.
REQ-034 In ACQUIRE, up_in=down_in=1 -> up_out=0, down_out=0 next cycle, and the counter increments (balanced).
REQ-035 In TRACK, en dropped for 1 cycle -> state=0, all outputs 0 next edge; en restored -> full 64-cycle PRECHARGE repeats.
REQ-036 rst pulsed during PRECHARGE cycle 30 -> all outputs 0 on the following edge; PRECHARGE restarts with a full 64-cycle count.
